priority_encoder_scanner: RTL
=============================

Name: priority_encoder_scanner

Overview:
Parametrised, sequential successor to the fixed 16:4 priority encoders.
- Captures a WIDTH-bit request vector through a valid/ready handshake.
- Emits the index of every set bit, one per accepted beat, in a selectable priority direction (lowest-first or highest-first).
- Sits between request-collecting logic and a downstream consumer that services one index at a time, e.g. an interrupt or arbitration dispatcher.

Parameters:
- WIDTH, 16, request vector width; must be ≥ 2.
- IDX_W, $clog2(WIDTH), width of the index and count outputs; derived, not overridden.

Ports:
- Clock_In  in  1  single clock; all state updates on its rising edge.
- Reset_n_In  in  1  asynchronous, active-low reset.
- Enable_In  in  1  when 0, all state holds: no capture, no advance, outputs hold.
- Flush_In  in  1  synchronous abort of the current vector.
- Mode_In  in  1  0 = lowest index first, 1 = highest index first; sampled at capture only.
- Data_In  in  WIDTH  request vector.
- Data_Valid_In  in  1  Data_In is valid.
- Data_Ready_Out  out  1  block can capture a vector (IDLE and Enable_In = 1).
- Index_Out  out  IDX_W  index of the current highest-priority pending bit.
- Index_Valid_Out  out  1  Index_Out is valid.
- Index_Ready_In  in  1  consumer accepts Index_Out.
- Last_Out  out  1  current index is the final pending bit.
- Count_Out  out  IDX_W+1  population count of the captured vector, held until the next capture.
- No_Request_Out  out  1  one-cycle pulse when an all-zero vector is captured.

Behaviour:
- Reset (asynchronous, Reset_n_In = 0): state = IDLE, pending = 0, latched mode = 0, Count_Out = 0, Index_Out = 0. Index_Valid_Out, Last_Out and No_Request_Out are 0. Data_Ready_Out = 0 while in reset, 1 from the first edge after release (provided Enable_In = 1).
- States: IDLE and EMIT.
- IDLE:
  - Capture occurs when Data_Valid_In & Data_Ready_Out.
  - On capture: pending ← Data_In, latched mode ← Mode_In, Count_Out ← popcount(Data_In).
  - Data_In ≠ 0 → EMIT.
  - Data_In = 0 → stay in IDLE and pulse No_Request_Out for the following cycle only.
- EMIT:
  - Index_Valid_Out = 1.
  - Index_Out = lowest set index of pending (mode 0) or highest set index (mode 1).
  - Last_Out = 1 when popcount(pending) = 1.
  - Beat accepted when Index_Valid_Out & Index_Ready_In & Enable_In: the emitted bit is cleared from pending.
  - If the accepted beat was Last_Out → IDLE.
- Latency:
  - First index is valid the cycle after capture.
  - One index per cycle under continuous Index_Ready_In.
  - Data_Ready_Out reasserts the cycle after the last beat is accepted; there is no capture in the same cycle as the last beat.
- Output timing: Index_Out, Last_Out and Index_Valid_Out are functions of registered state only. There is no combinational path from Data_In or Mode_In to any output.
- Backpressure: while Index_Ready_In = 0, Index_Out, Last_Out and Index_Valid_Out hold stable.
- Mode_In changes during EMIT have no effect.
- Flush_In = 1 (with Enable_In = 1):
  - Next state IDLE, pending = 0, Index_Valid_Out = 0 from the next cycle; Count_Out is retained.
  - Flush takes priority over a simultaneous beat acceptance or capture.
  - Flush in IDLE blocks capture that cycle.
- Enable_In = 0: overrides everything except reset, including Flush_In. Data_Ready_Out = 0; Index_Valid_Out holds its value but no beat is consumed.
- Arithmetic: popcount is computed over WIDTH bits into IDX_W+1 bits, so an all-ones vector gives WIDTH without overflow.

Decomposition:
- Package priority_encoder_scanner_pkg:
  - state enum {IDLE, EMIT};
  - mode constants MODE_LOW_FIRST = 1'b0 and MODE_HIGH_FIRST = 1'b1;
  - popcount function, parameterised by width.
- Sub-module priority_pick:
  - combinational, parameter WIDTH;
  - inputs: vector, direction;
  - outputs: index, one-hot pick mask, any-set flag.
  - Instantiated once on pending; the top level clears a bit with pending & ~mask.

Test Plan:
- Reset: assert Reset_n_In mid-EMIT on 16'hFFFF → Index_Valid_Out drops immediately (asynchronously). After release: Count_Out = 0, Data_Ready_Out = 1.
- Mode 0, Data_In = 16'h8421, Index_Ready_In = 1 → Index_Out = 0, 5, 10, 15 on four consecutive cycles starting the cycle after capture. Last_Out is high only with 15; Count_Out = 4; Data_Ready_Out = 1 the following cycle.
- Mode 1, Data_In = 16'h8421 → sequence 15, 10, 5, 0. Toggling Mode_In during the sequence leaves the order unchanged.
- Backpressure: mode 0, 16'h0003, Index_Ready_In held 0 for 3 cycles → Index_Out = 0 with valid held stable. Then Index_Ready_In = 1 → 0 then 1, Last_Out on 1.
- Zero vector: Data_In = 0 captured → No_Request_Out high for exactly one cycle, Index_Valid_Out stays 0, Count_Out = 0, Data_Ready_Out stays 1.
- Flush/enable: 16'hFFFF in mode 0, flush after indices 0, 1, 2 accepted → valid low the next cycle, IDLE, Count_Out = 16. Enable_In = 0 for 2 cycles mid-sequence → Index_Out held, no beats consumed.

Source files
------------

// File: rtl/priority_encoder_scanner_pkg.sv
// Shared types, direction constants and a population-count helper for the
// priority encoder scanner.
package priority_encoder_scanner_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } state_e;

  localparam logic MODE_LOW_FIRST  = 1'b0;
  localparam logic MODE_HIGH_FIRST = 1'b1;

  // Callers zero-extend their vector to PopMaxW and pass their real width.
  localparam int unsigned PopMaxW = 256;

  function automatic int unsigned popcount(input logic [PopMaxW-1:0] vec,
                                           input int unsigned        width);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < PopMaxW; i++) begin
      if ((i < width) && vec[i]) cnt += 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/priority_encoder_scanner_if.sv
// Request-capture and index-emit handshake bundle of the priority encoder scanner.
interface priority_encoder_scanner_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] data;
  logic             mode;
  logic             data_valid;
  logic             data_ready;
  logic [IDX_W-1:0] index;
  logic             index_valid;
  logic             index_ready;
  logic             last;
  logic [IDX_W:0]   count;
  logic             no_request;

  modport master (
    output data, mode, data_valid, index_ready,
    input  data_ready, index, index_valid, last, count, no_request
  );

  modport slave (
    input  data, mode, data_valid, index_ready,
    output data_ready, index, index_valid, last, count, no_request
  );

endinterface

// File: rtl/priority_encoder_scanner_pick.sv
// Combinational picker: returns the highest-priority set bit of a vector in the
// requested direction, as an index and a one-hot mask.
module priority_pick
  import priority_encoder_scanner_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic             dir_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             any_o
);

  // Later loop iterations win, so scan order is the reverse of priority.
  always_comb begin
    idx_o  = '0;
    mask_o = '0;
    any_o  = |vec_i;
    if (dir_i == MODE_HIGH_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (vec_i[i]) begin
          idx_o     = IDX_W'(i);
          mask_o    = '0;
          mask_o[i] = 1'b1;
        end
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (vec_i[i]) begin
          idx_o     = IDX_W'(i);
          mask_o    = '0;
          mask_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/priority_encoder_scanner.sv
// Captures a request vector and emits the index of each set bit, one per
// accepted beat, lowest-first or highest-first.
module priority_encoder_scanner
  import priority_encoder_scanner_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH),
  localparam int unsigned CntW  = IDX_W + 1
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  input logic                        enable_i,
  input logic                        flush_i,
  priority_encoder_scanner_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             mode_q, mode_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             no_req_q, no_req_d;
  logic             out_of_reset_q;

  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_mask;
  logic             pick_any;
  logic             last;
  logic             capture;

  priority_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .vec_i  (pending_q),
    .dir_i  (mode_q),
    .idx_o  (pick_idx),
    .mask_o (pick_mask),
    .any_o  (pick_any)
  );

  assign last    = (state_q == StEmit) && pick_any && ((pending_q & ~pick_mask) == '0);
  assign capture = bus.data_valid && bus.data_ready;

  // Ready stays low until the first edge after reset release.
  assign bus.data_ready  = out_of_reset_q && enable_i && (state_q == StIdle);
  assign bus.index       = pick_idx;
  assign bus.index_valid = (state_q == StEmit);
  assign bus.last        = last;
  assign bus.count       = count_q;
  assign bus.no_request  = no_req_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    count_d   = count_q;
    no_req_d  = no_req_q;
    if (enable_i) begin
      no_req_d = 1'b0;
      if (flush_i) begin
        state_d   = StIdle;
        pending_d = '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (capture) begin
              pending_d = bus.data;
              mode_d    = bus.mode;
              count_d   = CntW'(popcount(PopMaxW'(bus.data), WIDTH));
              if (bus.data != '0) state_d  = StEmit;
              else                no_req_d = 1'b1;
            end
          end
          StEmit: begin
            if (bus.index_ready) begin
              pending_d = pending_q & ~pick_mask;
              if (last) state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      mode_q         <= MODE_LOW_FIRST;
      count_q        <= '0;
      no_req_q       <= 1'b0;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      mode_q         <= mode_d;
      count_q        <= count_d;
      no_req_q       <= no_req_d;
      out_of_reset_q <= 1'b1;
    end
  end

endmodule
